sme_param: RTL and testbench
============================

# sme_param

Parametrised string-matching engine for the SME contest line. It streams in a text string and a search pattern over a shared character bus, then scans every candidate alignment and reports the outcome in a single `valid` pulse: first-match flag, first-match index and total match count. String and pattern depths and character width are parameters. The block sits behind the existing character-stream front end used by the SME testbenches.

## Interface
- `STR_DEPTH`, 32: maximum stored string characters.
- `PAT_DEPTH`, 8: maximum stored pattern characters, anchors included.
- `CHAR_W`, 8: character width in bits.
- `IDX_W`, $clog2(STR_DEPTH): width of `match_index`.
- `CNT_W`, $clog2(STR_DEPTH+1): width of `match_count`.
- `clk`  in  1  rising-edge clock; the block's only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `chardata`  in  CHAR_W  character sampled while `isstring` or `ispattern` is high.
- `isstring`  in  1  string-load strobe, one character per cycle.
- `ispattern`  in  1  pattern-load strobe, one character per cycle.
- `valid`  out  1  one-cycle result strobe.
- `match`  out  1  at least one alignment matched.
- `match_index`  out  IDX_W  start position of the lowest matching alignment.
- `match_count`  out  CNT_W  number of matching alignments.

## Operation
- **States:** IDLE, LOAD_STR, LOAD_PAT, SEARCH, DONE.
- **Reset (asynchronous):** state=IDLE; string length and pattern length = 0. Outputs: `valid`=0, `match`=0, `match_index`=0, `match_count`=0.
- **String load (IDLE/LOAD_STR):** while `isstring`=1, store `chardata` at `slen`, then `slen`++.
  - The first `isstring` cycle after IDLE clears `slen` to 0 before the store, so a new string replaces the old one.
  - Characters beyond `STR_DEPTH` are dropped; `slen` saturates at `STR_DEPTH`.
- **Pattern load (IDLE/LOAD_PAT):** same rule with `plen`, saturating at `PAT_DEPTH`. The stored string is retained, so multiple patterns can run against one string.
- **Strobe conflict:** if `isstring` and `ispattern` are high together, `isstring` wins and the pattern strobe is ignored that cycle.
- **Search start:** the first cycle in LOAD_PAT with `ispattern`=0 moves the FSM to SEARCH with p=0.
- **SEARCH:** evaluates one alignment p per cycle, p = 0..`slen` inclusive, then moves to DONE.
- **Pattern semantics:**
  - `^` (8'h5E) is legal only as the first pattern character. It is zero-width and succeeds at p when p==0 or str[p-1]==8'h20.
  - `$` (8'h24) is legal only as the last pattern character. It is zero-width and succeeds when the body ends at `slen` or the next string character is 8'h20.
  - `.` (8'h2E) matches any single character.
  - Any other character must compare equal.
  - A body character that falls past `slen` fails the alignment.
- **Result:** `match_index` = lowest matching p. `match_count` = number of matching p. `match` = (`match_count`≠0).
- **DONE:** drive the result with `valid`=1 for exactly one cycle, then return to IDLE. Outside this cycle `valid`=0; `match`, `match_index` and `match_count` hold their last values.
- **Ignored input:** `isstring` and `ispattern` are ignored in SEARCH and DONE.
- **Empty pattern** (`plen`=0): every p matches; index 0; count `slen`+1.

## Timing
- Last pattern character accepted in cycle T; SEARCH begins at T+1.
- `valid` asserts at T+`slen`+3. With `slen`=32 that is T+35.
- The latency is fixed, independent of the match outcome.
- New load strobes are accepted from the cycle after `valid`.
- Reset asserted mid-SEARCH aborts the search immediately; no `valid` is issued.

## Configuration
- `SME_CASE_FOLD_EN` defined: ASCII letters 8'h41–8'h5A and 8'h61–8'h7A compare case-insensitively. Applies to literal pattern characters only; anchors and `.` are unaffected.
- Not defined: all comparisons are exact.

## Structure
- **`sme_pkg`** holds:
  - character constants `CHR_CARET`, `CHR_DOLLAR`, `CHR_DOT`, `CHR_SPACE`;
  - the FSM state enum `sme_state_t`.
- **`sme_align_cmp`** (combinational sub-module) evaluates one alignment p across all `PAT_DEPTH` slots in parallel and returns pass/fail.
- **`sme_param`** owns the buffers, lengths, FSM, scan counter and result registers.

## Test plan
- String "hello world", pattern "^wor" -> `match`=1, `match_index`=6, `match_count`=1.
- Same string, pattern "o" -> `match`=1, `match_index`=4, `match_count`=2. Pattern "ld$" -> `match`=1, `match_index`=9, `match_count`=1.
- Same string, pattern "h.z" -> `match`=0, `match_count`=0; `valid` still arrives at T+14 (`slen`=11).
- 40-character string "a"×40 with `STR_DEPTH`=32, then pattern "a$" -> `match`=1, `match_index`=31, `match_count`=1.
- String "HELLO", pattern "hel": with `SME_CASE_FOLD_EN` -> `match`=1, `match_index`=0; without it -> `match`=0.
- Drop `reset_n` two cycles into SEARCH -> all outputs 0 and no `valid`. After reset release, reload "ab" and pattern "b" -> `match`=1, `match_index`=1.

Source files
------------

// File: rtl/sme_pkg.sv
// Shared constants and FSM state type for the SME string-matching engine.
// Case-insensitive matching is enabled by defining SME_CASE_FOLD_EN.
package sme_pkg;

   localparam logic [7:0] CHR_CARET  = 8'h5E;
   localparam logic [7:0] CHR_DOLLAR = 8'h24;
   localparam logic [7:0] CHR_DOT    = 8'h2E;
   localparam logic [7:0] CHR_SPACE  = 8'h20;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_STR,
      LOAD_PAT,
      SEARCH,
      DONE
   } sme_state_t;

endpackage

// File: rtl/sme_align_cmp.sv
// Combinational check of one alignment of the stored pattern against the string.
// With SME_CASE_FOLD_EN defined, literal ASCII letters compare case-insensitively.
module sme_align_cmp
   import sme_pkg::*;
#(
   parameter int STR_DEPTH = 32,
   parameter int PAT_DEPTH = 8,
   parameter int CHAR_W    = 8,
   parameter int CNT_W     = $clog2(STR_DEPTH + 1),
   parameter int PLEN_W    = $clog2(PAT_DEPTH + 1)
) (
   input  logic [STR_DEPTH*CHAR_W-1:0] str,
   input  logic [CNT_W-1:0]            slen,
   input  logic [PAT_DEPTH*CHAR_W-1:0] pat,
   input  logic [PLEN_W-1:0]           plen,
   input  logic [CNT_W-1:0]            pos,
   output logic                        hit
);

`ifdef SME_CASE_FOLD_EN
   function automatic logic [CHAR_W-1:0] fold(input logic [CHAR_W-1:0] c);
      if (c >= CHAR_W'(8'h41) && c <= CHAR_W'(8'h5A))
         return c | CHAR_W'(8'h20);
      return c;
   endfunction
`endif

   // Anchors are zero-width, so the body occupies pattern slots [body_lo, body_hi).
   always_comb begin
      int p_i;
      int s_i;
      int last;
      int body_lo;
      int body_hi;
      int at;
      logic has_caret;
      logic has_dollar;
      logic [CHAR_W-1:0] pc;
      logic [CHAR_W-1:0] sc;

      hit        = 1'b1;
      p_i        = int'(pos);
      s_i        = int'(slen);
      last       = (plen == '0) ? 0 : int'(plen) - 1;
      has_caret  = (plen != '0) && (pat[CHAR_W-1:0] == CHAR_W'(CHR_CARET));
      has_dollar = (plen != '0) && (pat[last*CHAR_W +: CHAR_W] == CHAR_W'(CHR_DOLLAR));
      body_lo    = has_caret ? 1 : 0;
      body_hi    = int'(plen) - (has_dollar ? 1 : 0);
      at         = 0;
      pc         = '0;
      sc         = '0;

      if (has_caret && p_i != 0) begin
         if (str[(p_i-1)*CHAR_W +: CHAR_W] != CHAR_W'(CHR_SPACE))
            hit = 1'b0;
      end

      for (int j = 0; j < PAT_DEPTH; j++) begin
         if (j >= body_lo && j < body_hi) begin
            at = p_i + j - body_lo;
            if (at >= s_i) begin
               hit = 1'b0;
            end else begin
               pc = pat[j*CHAR_W +: CHAR_W];
               sc = str[at*CHAR_W +: CHAR_W];
`ifdef SME_CASE_FOLD_EN
               if (pc != CHAR_W'(CHR_DOT) && fold(pc) != fold(sc))
                  hit = 1'b0;
`else
               if (pc != CHAR_W'(CHR_DOT) && pc != sc)
                  hit = 1'b0;
`endif
            end
         end
      end

      if (has_dollar) begin
         at = p_i + body_hi - body_lo;
         if (at < s_i) begin
            if (str[at*CHAR_W +: CHAR_W] != CHAR_W'(CHR_SPACE))
               hit = 1'b0;
         end else if (at > s_i) begin
            hit = 1'b0;
         end
      end
   end

endmodule

// File: rtl/sme_param.sv
// Parametrised string-matching engine: loads a string and pattern, scans all alignments.
// Define SME_CASE_FOLD_EN for case-insensitive literal letter comparison.
module sme_param
   import sme_pkg::*;
#(
   parameter int STR_DEPTH = 32,
   parameter int PAT_DEPTH = 8,
   parameter int CHAR_W    = 8,
   parameter int IDX_W     = $clog2(STR_DEPTH),
   parameter int CNT_W     = $clog2(STR_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [CHAR_W-1:0] chardata,
   input  logic              isstring,
   input  logic              ispattern,
   output logic              valid,
   output logic              match,
   output logic [IDX_W-1:0]  match_index,
   output logic [CNT_W-1:0]  match_count
);

   localparam int PLEN_W = $clog2(PAT_DEPTH + 1);

   sme_state_t state;
   sme_state_t next_state;

   logic [STR_DEPTH*CHAR_W-1:0] str_buf;
   logic [PAT_DEPTH*CHAR_W-1:0] pat_buf;
   logic [CNT_W-1:0]            slen;
   logic [PLEN_W-1:0]           plen;
   logic [CNT_W-1:0]            pos;
   logic [CNT_W-1:0]            acc_cnt;
   logic [IDX_W-1:0]            acc_idx;
   logic                        hit;

   logic str_we;
   logic pat_we;
   logic load_first;
   logic scan_start;
   logic scan_step;
   logic finish;

   logic [CNT_W-1:0]  str_wr;
   logic [PLEN_W-1:0] pat_wr;

   assign str_wr = load_first ? '0 : slen;
   assign pat_wr = load_first ? '0 : plen;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   // A string strobe takes priority over a simultaneous pattern strobe.
   always_comb begin
      next_state = state;
      str_we     = 1'b0;
      pat_we     = 1'b0;
      load_first = 1'b0;
      scan_start = 1'b0;
      scan_step  = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (isstring) begin
               str_we     = 1'b1;
               load_first = 1'b1;
               next_state = LOAD_STR;
            end else if (ispattern) begin
               pat_we     = 1'b1;
               load_first = 1'b1;
               next_state = LOAD_PAT;
            end
         end
         LOAD_STR: begin
            if (isstring)
               str_we = 1'b1;
            else
               next_state = IDLE;
         end
         LOAD_PAT: begin
            if (ispattern && !isstring) begin
               pat_we = 1'b1;
            end else begin
               scan_start = 1'b1;
               next_state = SEARCH;
            end
         end
         SEARCH: begin
            scan_step = 1'b1;
            if (pos == slen)
               next_state = DONE;
         end
         DONE: begin
            finish     = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Character storage is not reset; the lengths alone define what is valid.
   always_ff @(posedge clk) begin
      if (str_we && str_wr < CNT_W'(STR_DEPTH))
         str_buf[str_wr*CHAR_W +: CHAR_W] <= chardata;
      if (pat_we && pat_wr < PLEN_W'(PAT_DEPTH))
         pat_buf[pat_wr*CHAR_W +: CHAR_W] <= chardata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slen <= '0;
         plen <= '0;
      end else begin
         if (str_we && str_wr < CNT_W'(STR_DEPTH))
            slen <= str_wr + CNT_W'(1);
         if (pat_we && pat_wr < PLEN_W'(PAT_DEPTH))
            plen <= pat_wr + PLEN_W'(1);
      end
   end

   sme_align_cmp #(
      .STR_DEPTH (STR_DEPTH),
      .PAT_DEPTH (PAT_DEPTH),
      .CHAR_W    (CHAR_W),
      .CNT_W     (CNT_W),
      .PLEN_W    (PLEN_W)
   ) u_cmp (
      .str  (str_buf),
      .slen (slen),
      .pat  (pat_buf),
      .plen (plen),
      .pos  (pos),
      .hit  (hit)
   );

   // Alignments are visited in ascending order, so the first hit is the lowest index.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pos         <= '0;
         acc_cnt     <= '0;
         acc_idx     <= '0;
         valid       <= 1'b0;
         match       <= 1'b0;
         match_index <= '0;
         match_count <= '0;
      end else begin
         valid <= 1'b0;
         if (scan_start) begin
            pos     <= '0;
            acc_cnt <= '0;
            acc_idx <= '0;
         end else if (scan_step) begin
            pos <= pos + CNT_W'(1);
            if (hit) begin
               acc_cnt <= acc_cnt + CNT_W'(1);
               if (acc_cnt == '0)
                  acc_idx <= pos[IDX_W-1:0];
            end
         end
         if (finish) begin
            valid       <= 1'b1;
            match       <= (acc_cnt != '0);
            match_index <= acc_idx;
            match_count <= acc_cnt;
         end
      end
   end

endmodule

// File: tb/tb_sme_param.sv
// Randomised bench for sme_param with a string-level reference model and directed anchors.
// Model honours SME_CASE_FOLD_EN the same way the design build does.
module tb_sme_param;

   localparam int STR_DEPTH = 32;
   localparam int PAT_DEPTH = 8;
   localparam int CHAR_W    = 8;
   localparam int IDX_W     = 5;
   localparam int CNT_W     = 6;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [CHAR_W-1:0] chardata = '0;
   logic              isstring = 1'b0;
   logic              ispattern = 1'b0;
   logic              valid;
   logic              match;
   logic [IDX_W-1:0]  match_index;
   logic [CNT_W-1:0]  match_count;

   sme_param dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .chardata    (chardata),
      .isstring    (isstring),
      .ispattern   (ispattern),
      .valid       (valid),
      .match       (match),
      .match_index (match_index),
      .match_count (match_count)
   );

   always #5 clk = ~clk;

   int edge_count = 0;
   always @(posedge clk) edge_count++;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] buf_q[$];
   logic [7:0] str_q[$];
   logic [7:0] pat_q[$];

   bit armed = 0;
   int exp_valid_at = 0;
   int t_last = 0;
   int pend_m, pend_i, pend_c;
   int exp_m = 0, exp_i = 0, exp_c = 0;
   int cap_m, cap_i, cap_c, cap_edge;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", name, actual, expected, edge_count);
      end
   endtask

   function automatic bit chr_eq(input logic [7:0] pc, input logic [7:0] sc);
      logic [7:0] a;
      logic [7:0] b;
      a = pc;
      b = sc;
      if (pc == 8'h2E) return 1'b1;
`ifdef SME_CASE_FOLD_EN
      if (a >= 8'h41 && a <= 8'h5A) a = a + 8'd32;
      if (b >= 8'h41 && b <= 8'h5A) b = b + 8'd32;
`endif
      return a == b;
   endfunction

   // Reference: try every start position of the body against the stored string.
   task automatic model_search(output int m, output int idx, output int cnt);
      int n;
      bit caret;
      bit dollar;
      logic [7:0] body[$];
      n = str_q.size();
      caret  = (pat_q.size() > 0) && (pat_q[0] == 8'h5E);
      dollar = (pat_q.size() > 0) && (pat_q[pat_q.size()-1] == 8'h24);
      body.delete();
      for (int k = (caret ? 1 : 0); k < pat_q.size() - (dollar ? 1 : 0); k++)
         body.push_back(pat_q[k]);
      cnt = 0;
      idx = 0;
      for (int p = 0; p <= n; p++) begin
         bit ok;
         int e;
         ok = 1'b1;
         if (caret && p > 0 && str_q[p-1] != 8'h20) ok = 1'b0;
         for (int k = 0; k < body.size(); k++)
            if (p + k >= n) ok = 1'b0;
            else if (!chr_eq(body[k], str_q[p+k])) ok = 1'b0;
         e = p + body.size();
         if (dollar && !(e == n || (e < n && str_q[e] == 8'h20))) ok = 1'b0;
         if (ok) begin
            if (cnt == 0) idx = p % (1 << IDX_W);
            cnt++;
         end
      end
      m = (cnt != 0) ? 1 : 0;
   endtask

   always @(negedge clk) begin
      if (armed && edge_count == exp_valid_at) begin
         check_output("valid_pulse", valid, 1);
         exp_m = pend_m;
         exp_i = pend_i;
         exp_c = pend_c;
         armed = 0;
         cap_m = match;
         cap_i = match_index;
         cap_c = match_count;
         cap_edge = edge_count;
      end else begin
         check_output("valid_idle", valid, 0);
      end
      check_output("match", match, exp_m);
      check_output("match_index", match_index, exp_i);
      check_output("match_count", match_count, exp_c);
   end

   task automatic put_text(input string t);
      buf_q.delete();
      for (int i = 0; i < t.len(); i++) buf_q.push_back(t[i]);
   endtask

   task automatic drive(input logic [7:0] c, input bit s, input bit p);
      chardata  = c;
      isstring  = s;
      ispattern = p;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus_string(input bit conflict);
      if (buf_q.size() == 0) return;
      str_q.delete();
      foreach (buf_q[i]) begin
         drive(buf_q[i], 1'b1, conflict ? 1'($urandom_range(0, 1)) : 1'b0);
         if (str_q.size() < STR_DEPTH) str_q.push_back(buf_q[i]);
      end
      drive(8'h00, 1'b0, 1'b0);
   endtask

   task automatic apply_stimulus_pattern(input bit junk, input int abort);
      pat_q.delete();
      foreach (buf_q[i]) begin
         drive(buf_q[i], 1'b0, 1'b1);
         if (pat_q.size() < PAT_DEPTH) pat_q.push_back(buf_q[i]);
      end
      t_last    = edge_count;
      isstring  = 1'b0;
      ispattern = 1'b0;
      chardata  = 8'($urandom);
      model_search(pend_m, pend_i, pend_c);
      exp_valid_at = t_last + str_q.size() + 3;
      armed = 1;
      while (edge_count < exp_valid_at) begin
         @(posedge clk);
         #1;
         if (abort > 0 && edge_count == t_last + 1 + abort) begin
            reset_n = 1'b0;
            armed = 0;
            exp_m = 0;
            exp_i = 0;
            exp_c = 0;
            str_q.delete();
            pat_q.delete();
            repeat (4) @(posedge clk);
            #1;
            check_output("abort_valid", valid, 0);
            check_output("abort_count", match_count, 0);
            reset_n = 1'b1;
            repeat (exp_valid_at - edge_count + 4) @(posedge clk);
            #1;
            return;
         end
         if (junk && edge_count < exp_valid_at) begin
            isstring  = 1'($urandom_range(0, 1));
            ispattern = 1'($urandom_range(0, 1));
            chardata  = 8'($urandom);
         end else begin
            isstring  = 1'b0;
            ispattern = 1'b0;
         end
      end
      @(negedge clk);
      #1;
      @(posedge clk);
      #1;
   endtask

   task automatic check_literal(input string name, input int m, input int i, input int c, input int lat);
      check_output({name, "_model_match"}, pend_m, m);
      check_output({name, "_model_count"}, pend_c, c);
      check_output({name, "_match"}, cap_m, m);
      check_output({name, "_index"}, cap_i, i);
      check_output({name, "_count"}, cap_c, c);
      if (lat >= 0) check_output({name, "_latency"}, cap_edge - t_last, lat);
   endtask

   function automatic logic [7:0] pick(input string alpha);
      return alpha[$urandom_range(0, alpha.len() - 1)];
   endfunction

   initial begin
      #400_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_valid", valid, 0);
      check_output("reset_match", match, 0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      put_text("hello world");
      apply_stimulus_string(1'b0);
      put_text("^wor");
      apply_stimulus_pattern(1'b0, 0);
      check_literal("caret_wor", 1, 6, 1, 14);
      put_text("o");
      apply_stimulus_pattern(1'b1, 0);
      check_literal("single_o", 1, 4, 2, 14);
      put_text("ld$");
      apply_stimulus_pattern(1'b0, 0);
      check_literal("dollar_ld", 1, 9, 1, -1);
      put_text("h.z");
      apply_stimulus_pattern(1'b1, 0);
      check_literal("nomatch_hz", 0, 0, 0, 14);

      buf_q.delete();
      repeat (40) buf_q.push_back(8'h61);
      apply_stimulus_string(1'b1);
      put_text("a$");
      apply_stimulus_pattern(1'b0, 0);
      check_literal("sat_a40", 1, 31, 1, 35);

      put_text("HELLO");
      apply_stimulus_string(1'b0);
      put_text("hel");
      apply_stimulus_pattern(1'b0, 0);
`ifdef SME_CASE_FOLD_EN
      check_literal("fold_hel", 1, 0, 1, 8);
`else
      check_literal("fold_hel", 0, 0, 0, 8);
`endif

      put_text("hello world");
      apply_stimulus_string(1'b0);
      put_text("o");
      apply_stimulus_pattern(1'b0, 2);
      put_text("ab");
      apply_stimulus_string(1'b0);
      put_text("b");
      apply_stimulus_pattern(1'b0, 0);
      check_literal("after_reset", 1, 1, 1, 5);

      for (int iter = 0; iter < 40; iter++) begin
         int blen;
         if (iter == 0 || $urandom_range(0, 1) == 1) begin
            buf_q.delete();
            repeat ($urandom_range(1, 40)) buf_q.push_back(pick("aab A."));
            apply_stimulus_string(1'b1);
         end
         buf_q.delete();
         if ($urandom_range(0, 2) == 0) buf_q.push_back(8'h5E);
         blen = $urandom_range(0, 4);
         repeat (blen) buf_q.push_back(pick("aab. A"));
         if ($urandom_range(0, 2) == 0) buf_q.push_back(8'h24);
         if (buf_q.size() == 0) buf_q.push_back(8'h61);
         apply_stimulus_pattern(1'($urandom_range(0, 1)), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
